// File: rtl/merge_layer_4_0_rx_pkg.sv
// merge_pkg: shared FSM state, counter width and element type for the merge layer
package merge_pkg;
  typedef enum logic [1:0] {IDLE, CAPTURE, MERGE, FINISH} state_t;
  localparam int DEF_DW = 8;
  localparam int DEF_LEN = 2;
  function automatic int cnt_w(input int len);
    return $clog2(len + 1);
  endfunction
  localparam int CNT_W = cnt_w(DEF_LEN);
  typedef logic [DEF_DW-1:0] elem_t;
endpackage

// File: rtl/merge_layer_4_0_rx_side_buf.sv
// merge_side_buf: LEN-deep write-once capture buffer with count and combinational read port
module merge_side_buf
  import merge_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int LEN = DEF_LEN,
  parameter int CW = CNT_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_wr,
  input  logic [DW-1:0] i_data,
  input  logic [CW-1:0] i_ptr,
  output logic [DW-1:0] o_data,
  output logic [CW-1:0] o_cnt,
  output logic          o_ovf
);
  localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] FULL = CW'(LEN);
  logic [DW-1:0] r_buf [LEN];
  logic [CW-1:0] r_cnt;
  logic w_full;
  assign w_full = r_cnt == FULL;
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
      for (int i = 0; i < LEN; i++) r_buf[i] <= '0;
    end else if (i_wr && !w_full) begin
      r_buf[r_cnt[IW-1:0]] <= i_data;
      r_cnt <= r_cnt + CW'(1);
    end
  end
  assign o_data = (i_ptr < FULL) ? r_buf[i_ptr[IW-1:0]] : '0;
  assign o_cnt = r_cnt;
  assign o_ovf = i_wr && w_full;
endmodule

// File: rtl/merge_layer_4_0_rx.sv
// merge_layer_4_0_rx: captures two sorted serial streams and emits their ascending merge
module merge_layer_4_0_rx
  import merge_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DW,
  parameter int LEN = DEF_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic                  a_update,
  input  logic                  a_done,
  input  logic [DATA_WIDTH-1:0] b_data,
  input  logic                  b_update,
  input  logic                  b_done,
  output logic [DATA_WIDTH-1:0] sorted_data,
  output logic                  update,
  output logic                  done,
  output logic                  overflow
);
  localparam int CW = (LEN == DEF_LEN) ? CNT_W : cnt_w(LEN);
  state_t r_state, w_next;
  logic r_a_fin, r_b_fin, r_ovf, r_upd, r_done;
  logic [DATA_WIDTH-1:0] r_data, w_a_rd, w_b_rd;
  logic [CW-1:0] r_ia, r_ib, w_a_cnt, w_b_cnt;
  logic [CW:0] w_tot, w_pos;
  logic w_clr, w_cap, w_both, w_take_a, w_last, w_emit, w_a_ovf, w_b_ovf;

  merge_side_buf #(.DW(DATA_WIDTH), .LEN(LEN), .CW(CW)) u_a (
    .clk(clk), .rst(rst), .i_clr(w_clr), .i_wr(w_cap && a_update), .i_data(a_data),
    .i_ptr(r_ia), .o_data(w_a_rd), .o_cnt(w_a_cnt), .o_ovf(w_a_ovf)
  );
  merge_side_buf #(.DW(DATA_WIDTH), .LEN(LEN), .CW(CW)) u_b (
    .clk(clk), .rst(rst), .i_clr(w_clr), .i_wr(w_cap && b_update), .i_data(b_data),
    .i_ptr(r_ib), .o_data(w_b_rd), .o_cnt(w_b_cnt), .o_ovf(w_b_ovf)
  );

  // w_pos is the emitted count after this cycle's emission
  always_comb begin
    w_clr = load && (r_state == IDLE || r_state == CAPTURE);
    w_cap = !load && r_state == CAPTURE;
    w_both = (r_a_fin || a_done) && (r_b_fin || b_done);
    w_tot = {1'b0, w_a_cnt} + {1'b0, w_b_cnt};
    w_pos = {1'b0, r_ia} + {1'b0, r_ib} + (CW+1)'(1);
    w_take_a = (r_ia < w_a_cnt) && (r_ib == w_b_cnt || w_a_rd <= w_b_rd);
    w_emit = r_state == MERGE && w_tot != '0;
    w_last = w_tot == '0 || w_pos == w_tot;
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = load ? CAPTURE : IDLE;
      CAPTURE: w_next = load ? CAPTURE : (w_both ? MERGE : CAPTURE);
      MERGE:   w_next = w_last ? FINISH : MERGE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_a_fin <= 1'b0;
      r_b_fin <= 1'b0;
      r_ovf <= 1'b0;
      r_upd <= 1'b0;
      r_done <= 1'b0;
      r_data <= '0;
      r_ia <= '0;
      r_ib <= '0;
    end else begin
      r_state <= w_next;
      r_a_fin <= !w_clr && (r_a_fin || (w_cap && a_done));
      r_b_fin <= !w_clr && (r_b_fin || (w_cap && b_done));
      r_ovf <= !w_clr && (r_ovf || w_a_ovf || w_b_ovf);
      r_upd <= w_emit;
      r_done <= r_state == FINISH;
      if (w_emit) begin
        r_data <= w_take_a ? w_a_rd : w_b_rd;
        r_ia <= r_ia + CW'(w_take_a);
        r_ib <= r_ib + CW'(!w_take_a);
      end else if (r_state != MERGE) begin
        r_ia <= '0;
        r_ib <= '0;
      end
    end
  end

  assign sorted_data = r_data;
  assign update = r_upd;
  assign done = r_done;
  assign overflow = r_ovf;
endmodule
